// File: rtl/ltc2324_rd.sv
// ltc2324_rd: LTC2324 four-lane serial readout; waits out conversion after sync falls, clocks NBITS SCK pulses, publishes four words.
module ltc2324_rd #(
  parameter int NBITS    = 16,
  parameter int WAIT_CYC = 8
) (
  input  logic             clk_10m,
  input  logic             rst_n,
  input  logic             sync,
  input  logic [3:0]       sdo,
  output logic             sck,
  output logic [NBITS-1:0] ch0_data,
  output logic [NBITS-1:0] ch1_data,
  output logic [NBITS-1:0] ch2_data,
  output logic [NBITS-1:0] ch3_data,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             ph_q, ph_d;
  logic             sck_q, sck_d;
  logic             sync_dly_q, sync_dly_d;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;
  logic [NBITS-1:0] sr_q [4];
  logic [NBITS-1:0] sr_d [4];
  logic [NBITS-1:0] ch_q [4];
  logic [NBITS-1:0] ch_d [4];
  logic             fall, rise;

  assign fall = sync_dly_q & ~sync;
  assign rise = ~sync_dly_q & sync;

  // sck is registered from the upcoming phase so it rises on the cycle SHIFT begins
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ph_d       = ph_q;
    sck_d      = 1'b0;
    sync_dly_d = sync;
    dv_d       = 1'b0;
    ovr_d      = ovr_q;
    sr_d       = sr_q;
    ch_d       = ch_q;
    if (rise && (state_q == S_WAIT || state_q == S_SHIFT)) begin
      state_d = S_IDLE;
      ovr_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (fall) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: if (cnt_q == CW'(WAIT_CYC - 1)) begin
          state_d = S_SHIFT;
          bit_d   = '0;
          ph_d    = 1'b0;
          sck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        S_SHIFT: if (!ph_q) begin
          ph_d = 1'b1;
          for (int i = 0; i < 4; i++) sr_d[i] = {sr_q[i][NBITS-2:0], sdo[i]};
        end else if (bit_q == BW'(NBITS - 1)) begin
          state_d = S_DONE;
        end else begin
          bit_d = bit_q + BW'(1);
          ph_d  = 1'b0;
          sck_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          ch_d    = sr_q;
          dv_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_10m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ph_q       <= 1'b0;
      sck_q      <= 1'b0;
      sync_dly_q <= 1'b0;
      dv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      sr_q       <= '{default: '0};
      ch_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      sck_q      <= sck_d;
      sync_dly_q <= sync_dly_d;
      dv_q       <= dv_d;
      ovr_q      <= ovr_d;
      sr_q       <= sr_d;
      ch_q       <= ch_d;
    end
  end

  assign sck        = sck_q;
  assign ch0_data   = ch_q[0];
  assign ch1_data   = ch_q[1];
  assign ch2_data   = ch_q[2];
  assign ch3_data   = ch_q[3];
  assign data_valid = dv_q;
  assign busy       = (state_q == S_WAIT) || (state_q == S_SHIFT);
  assign overrun    = ovr_q;
endmodule
